// File: rtl/enc_param_ctrl_if.sv
// Encoder/button inputs and parameter-register outputs of enc_param_ctrl.
// The bench drives the master side; the controller uses the slave side.
interface enc_param_ctrl_if #(
  parameter int N_CH = 4,
  parameter int W    = 5
);
  localparam int SEL_W = $clog2(N_CH);

  logic              enc_a;
  logic              enc_b;
  logic              btn;
  logic [SEL_W-1:0]  sel;
  logic [W-1:0]      value;
  logic [N_CH*W-1:0] all_values;
  logic              step_pulse;
  logic [1:0]        LED;

  modport master (
    output enc_a, enc_b, btn,
    input  sel, value, all_values, step_pulse, LED
  );

  modport slave (
    input  enc_a, enc_b, btn,
    output sel, value, all_values, step_pulse, LED
  );
endinterface

// File: rtl/enc_param_ctrl.sv
// One rotary encoder shared by N_CH registers: a step lands 3 clk after the A edge; the inputs are never stalled.
// Short press selects the next register, long press clears it; define ENC_WRAP_EN for wrap-around instead of saturation.
module enc_param_ctrl #(
  parameter int N_CH         = 4,
  parameter int W            = 5,
  parameter int MAX_VAL      = 19,
  parameter int BTN_DEB_CYC  = 1_000_000,
  parameter int BTN_HOLD_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  enc_param_ctrl_if.slave  bus
);
  localparam int SEL_W  = $clog2(N_CH);
  localparam int DEB_W  = $clog2(BTN_DEB_CYC + 1);
  localparam int HOLD_W = $clog2(BTN_HOLD_CYC + 1);

  typedef enum logic [1:0] {B_ARM, B_IDLE, B_PRESS, B_HELD} btn_st_t;

  logic r_a_s1, r_a_s2, r_a_d;
  logic r_b_s1, r_b_s2;
  logic r_btn_s1, r_btn_s2;
  logic r_step_vld, r_step_cw;

  btn_st_t             r_state, w_state_nxt;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                w_btn_tgt, w_btn_match, w_deb_done, w_hold_done;
  logic                w_sel_adv, w_clear;

  logic [W-1:0]        r_regs [N_CH];
  logic [W-1:0]        w_regs_nxt [N_CH];
  logic [SEL_W-1:0]    r_sel, w_sel_nxt;
  logic [W-1:0]        r_value;
  logic                r_step_pulse, r_led0;
  logic [W-1:0]        w_cur, w_stepped;
  logic [W:0]          w_sum;

  // The registered edge detect adds the third stage of step latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_s1     <= 1'b0;
      r_a_s2     <= 1'b0;
      r_a_d      <= 1'b0;
      r_b_s1     <= 1'b0;
      r_b_s2     <= 1'b0;
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_step_vld <= 1'b0;
      r_step_cw  <= 1'b0;
    end else begin
      r_a_s1     <= bus.enc_a;
      r_a_s2     <= r_a_s1;
      r_a_d      <= r_a_s2;
      r_b_s1     <= bus.enc_b;
      r_b_s2     <= r_b_s1;
      r_btn_s1   <= bus.btn;
      r_btn_s2   <= r_btn_s1;
      r_step_vld <= r_a_s2 & ~r_a_d;
      r_step_cw  <= ~r_b_s2;
    end
  end

  assign w_btn_tgt   = (r_state == B_IDLE);
  assign w_btn_match = (r_btn_s2 == w_btn_tgt);
  assign w_deb_done  = w_btn_match && (r_deb_cnt == DEB_W'(BTN_DEB_CYC - 1));
  assign w_hold_done = (r_state == B_PRESS) && (r_hold_cnt == HOLD_W'(BTN_HOLD_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_sel_adv   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      B_ARM:   if (w_deb_done) w_state_nxt = B_IDLE;
      B_IDLE:  if (w_deb_done) w_state_nxt = B_PRESS;
      B_PRESS: begin
        if (w_hold_done) begin
          w_clear     = 1'b1;
          w_state_nxt = B_HELD;
        end else if (w_deb_done) begin
          w_sel_adv   = 1'b1;
          w_state_nxt = B_IDLE;
        end
      end
      B_HELD:  if (w_deb_done) w_state_nxt = B_IDLE;
      default: w_state_nxt = B_ARM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= B_ARM;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || !w_btn_match)
        r_deb_cnt <= '0;
      else if (r_deb_cnt < DEB_W'(BTN_DEB_CYC))
        r_deb_cnt <= r_deb_cnt + 1'b1;
      if ((r_state != B_PRESS) || (w_state_nxt != r_state))
        r_hold_cnt <= '0;
      else if (r_hold_cnt < HOLD_W'(BTN_HOLD_CYC))
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  always_comb begin
    w_regs_nxt = r_regs;
    w_cur      = r_regs[r_sel];
    w_stepped  = w_cur;
    if (r_step_cw) begin
      w_sum = {1'b0, w_cur} + 1'b1;
      if (w_sum > (W+1)'(MAX_VAL))
`ifdef ENC_WRAP_EN
        w_stepped = '0;
`else
        w_stepped = W'(MAX_VAL);
`endif
      else
        w_stepped = w_sum[W-1:0];
    end else begin
      w_sum = {1'b0, w_cur} - 1'b1;
      if (w_sum[W])
`ifdef ENC_WRAP_EN
        w_stepped = W'(MAX_VAL);
`else
        w_stepped = '0;
`endif
      else
        w_stepped = w_sum[W-1:0];
    end
    // A long-press clear overrides a coincident step on the same register.
    if (w_clear)
      w_regs_nxt[r_sel] = '0;
    else if (r_step_vld)
      w_regs_nxt[r_sel] = w_stepped;
    if (w_sel_adv)
      w_sel_nxt = (r_sel == SEL_W'(N_CH - 1)) ? '0 : r_sel + 1'b1;
    else
      w_sel_nxt = r_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) r_regs[i] <= '0;
      r_sel        <= '0;
      r_value      <= '0;
      r_step_pulse <= 1'b0;
      r_led0       <= 1'b0;
    end else begin
      r_regs       <= w_regs_nxt;
      r_sel        <= w_sel_nxt;
      r_value      <= w_regs_nxt[w_sel_nxt];
      r_step_pulse <= r_step_vld;
      if (r_step_vld) r_led0 <= r_step_cw;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_all
    assign bus.all_values[g*W +: W] = r_regs[g];
  end

  assign bus.sel        = r_sel;
  assign bus.value      = r_value;
  assign bus.step_pulse = r_step_pulse;
  assign bus.LED        = {(r_state == B_PRESS) || (r_state == B_HELD), r_led0};
endmodule

// File: tb/tb_enc_param_ctrl.sv
// Directed and randomized checks of enc_param_ctrl against a value-level model of the registers and selection.
module tb_enc_param_ctrl;
  localparam int N_CH = 4;
  localparam int W    = 5;
  localparam int MAXV = 19;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  enc_param_ctrl_if #(.N_CH(N_CH), .W(W)) bus ();

  enc_param_ctrl #(
    .N_CH(N_CH), .W(W), .MAX_VAL(MAXV), .BTN_DEB_CYC(4), .BTN_HOLD_CYC(40)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int m_reg [N_CH];
  int m_sel  = 0;
  int m_led0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int step_ref(input int v, input bit cw);
    int nv;
    nv = cw ? v + 1 : v - 1;
`ifdef ENC_WRAP_EN
    if (nv > MAXV) nv = 0;
    if (nv < 0)    nv = MAXV;
`else
    if (nv > MAXV) nv = MAXV;
    if (nv < 0)    nv = 0;
`endif
    return nv;
  endfunction

  function automatic logic [31:0] exp_all();
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < N_CH; i++) e[i*W +: W] = W'(m_reg[i]);
    return e;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_sel"},   32'(bus.sel),        32'(m_sel));
    chk({tag, "_value"}, 32'(bus.value),      32'(m_reg[m_sel]));
    chk({tag, "_all"},   32'(bus.all_values), exp_all());
    chk({tag, "_led0"},  32'(bus.LED[0]),     32'(m_led0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_reg[i] = 0;
    m_sel  = 0;
    m_led0 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.enc_a = 1'b0; bus.enc_b = 1'b0; bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
  endtask

  // A rises on the negedge before edge0; the step must be visible after edge3.
  task automatic detent(input bit cw);
    @(negedge clk);
    bus.enc_b = cw ? 1'b0 : 1'b1;
    @(negedge clk);
    bus.enc_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pulse_early", 32'(bus.step_pulse), 32'd0);
    end
    @(negedge clk);
    chk("pulse_on_time", 32'(bus.step_pulse), 32'd1);
    m_reg[m_sel] = step_ref(m_reg[m_sel], cw);
    m_led0 = cw;
    check_state("step");
    @(negedge clk);
    chk("pulse_one_cycle", 32'(bus.step_pulse), 32'd0);
    bus.enc_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic short_press();
    @(negedge clk);
    bus.btn = 1'b1;
    repeat (9) @(negedge clk);
    chk("short_led1_on", 32'(bus.LED[1]), 32'd1);
    @(negedge clk);
    bus.btn = 1'b0;
    repeat (12) @(negedge clk);
    m_sel = (m_sel + 1) % N_CH;
    check_state("short");
    chk("short_led1_off", 32'(bus.LED[1]), 32'd0);
  endtask

  task automatic long_press(input bit with_step, input bit cw);
    int sel_before;
    sel_before = m_sel;
    @(negedge clk);
    bus.btn = 1'b1;
    repeat (20) @(negedge clk);
    chk("long_led1_mid", 32'(bus.LED[1]), 32'd1);
    repeat (30) @(negedge clk);
    m_reg[m_sel] = 0;
    check_state("long_clear");
    chk("long_led1_held", 32'(bus.LED[1]), 32'd1);
    if (with_step) detent(cw);
    chk("long_led1_after_step", 32'(bus.LED[1]), 32'd1);
    bus.btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("long_sel_kept", 32'(bus.sel), 32'(sel_before));
    check_state("long_release");
    chk("long_led1_off", 32'(bus.LED[1]), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    bus.enc_a = 1'b0; bus.enc_b = 1'b0; bus.btn = 1'b0;
    model_reset();
    #23;
    check_state("reset");
    chk("reset_pulse", 32'(bus.step_pulse), 32'd0);
    chk("reset_led",   32'(bus.LED),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: three CW detents on reg0
    repeat (3) detent(1'b1);
    chk("t1_reg0", 32'(bus.value), 32'd3);

    // 2: next register, two CCW detents at the bottom
    short_press();
    repeat (2) detent(1'b0);
    chk("t2_sel", 32'(bus.sel), 32'd1);

    // 3: climb to MAX_VAL, then one more CW at the top
    guard = 0;
    while (m_reg[m_sel] != MAXV && guard < 40) begin
      detent(1'b1);
      guard++;
    end
    chk("t3_at_max", 32'(bus.value), 32'(MAXV));
    detent(1'b1);

    // 4: long press clear with a step while held
    detent(1'b1);
    long_press(1'b1, 1'b1);

    // Randomized mix of detents and presses
    for (int it = 0; it < 25; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 7)       detent(1'($urandom_range(0, 1)));
      else if (act < 9)  short_press();
      else               long_press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // 5: short glitches are ignored
    repeat (3) begin
      @(negedge clk); bus.btn = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn = 1'b0;
      repeat (6) @(negedge clk);
      chk("glitch_led1", 32'(bus.LED[1]), 32'd0);
      check_state("glitch");
    end

    // 5b: button held across reset release is ignored until released
    @(negedge clk);
    reset_n = 1'b0;
    bus.btn = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (30) @(negedge clk);
    chk("arm_led1", 32'(bus.LED[1]), 32'd0);
    check_state("arm_hold");
    bus.btn = 1'b0;
    repeat (10) @(negedge clk);
    check_state("arm_release");
    short_press();

    // 6: asynchronous reset in the middle of a press
    repeat (2) detent(1'b1);
    @(negedge clk);
    bus.btn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_led1_before", 32'(bus.LED[1]), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    chk("async_rst_pulse", 32'(bus.step_pulse), 32'd0);
    chk("async_rst_led",   32'(bus.LED),        32'd0);
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    detent(1'b0);
    short_press();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
